uart_cmd_framer: RTL
====================

// Module: uart_cmd_framer
// PURPOSE
// Parametrised command framer between a byte-level UART (rx_rdy/rx_data/clr_rx_rdy, trmt/tx_data/tx_done) and the command consumer.
// Assembles CMD_BYTES received bytes into one command word and discards stale partial frames after an inter-byte timeout.
// Serialises a RESP_BYTES-wide response into back-to-back UART transmissions.
// The UART is instantiated alongside this block at the next level up, not inside it.
// PARAMETERS
// CMD_BYTES       3    bytes per command frame (>=1)
// RESP_BYTES      2    bytes per response (>=1)
// MSB_FIRST       1    1: first byte on the wire is the most significant; 0: least significant first (RX and TX)
// TIMEOUT_CYCLES  1024 idle clk cycles allowed between bytes of one frame; 0 disables the timeout
// PORTS
// clk         in   1               system clock, all logic on rising edge
// rst         in   1               synchronous, active-high reset
// rx_rdy      in   1               UART has a received byte
// rx_data     in   8               received byte
// clr_rx_rdy  out  1               acknowledge/clear of rx_rdy
// cmd         out  8*CMD_BYTES     last complete command
// cmd_rdy     out  1               complete command available
// clr_cmd_rdy in   1               consumer clears cmd_rdy
// frame_err   out  1               1-cycle pulse: partial frame discarded on timeout
// resp        in   8*RESP_BYTES    response word, sampled on send_resp
// send_resp   in   1               request to transmit resp
// resp_busy   out  1               response transmission in progress
// resp_done   out  1               1-cycle pulse: last response byte finished
// trmt        out  1               UART transmit strobe
// tx_data     out  8               byte to transmit
// tx_done     in   1               UART finished the current byte; the UART clears it on the edge at which it samples trmt
// BEHAVIOUR
// - Reset: all outputs 0; cmd=0; byte counter, timer and response index 0; TX FSM in IDLE. A reset mid-frame or mid-response discards the frame or response; no trmt after reset.
// - RX: clr_rx_rdy = rx_rdy, combinational, in the same cycle. Each accepted byte shifts into a frame register:
//   - MSB_FIRST=1: shift left, new byte at bits [7:0].
//   - MSB_FIRST=0: shift right, new byte at the top.
// - Byte counter 0..CMD_BYTES-1. On the byte that completes a frame: cmd <= assembled word and cmd_rdy <= 1 on the same edge; counter back to 0.
// - cmd is stable between completed frames; partial frames never alter cmd.
// - cmd_rdy is cleared by clr_cmd_rdy or by acceptance of the first byte of the next frame. A set in the same cycle as a clear leaves cmd_rdy at 1 (set wins).
//   - CMD_BYTES=1: every byte sets, so set wins.
// - Timeout: the timer counts while counter!=0 and is zeroed on each accepted byte.
//   - Timer reaching TIMEOUT_CYCLES: counter <= 0, frame register <= 0, frame_err pulses 1 cycle; cmd and cmd_rdy are untouched.
//   - rx_rdy in the expiry cycle: the byte is accepted as a continuation and no error is raised (byte wins).
//   - Timer width is $clog2(TIMEOUT_CYCLES+1) and saturates, so it never wraps.
// - TX FSM:
//   - IDLE: on send_resp, latch resp, index <= 0, go LOAD; resp_busy=1 in every state except IDLE.
//   - LOAD: trmt=1 for exactly 1 cycle, tx_data = byte[index]; go WAIT.
//   - WAIT: tx_done sampled only here. If tx_done and index==RESP_BYTES-1: resp_done pulse, go IDLE. Otherwise, on tx_done, index++ and go LOAD.
// - TX byte order: MSB_FIRST=1 sends resp[8*RESP_BYTES-1 -:8] first; MSB_FIRST=0 sends resp[7:0] first.
// - tx_data holds the current byte from LOAD through WAIT, and the last byte in IDLE.
// - send_resp while resp_busy is ignored; the latched response is unaffected by later resp changes.
// - Minimum gap between two responses: send_resp is accepted in the cycle after resp_done.
// - RX and TX paths are independent: they operate concurrently with no interaction.
// TESTING
// 1. CMD_BYTES=3, MSB_FIRST=1: bytes A5,3C,0F, 40 cycles apart -> clr_rx_rdy on each rx_rdy; cmd=0xA53C0F and cmd_rdy=1 on the edge of the 3rd byte; no frame_err.
// 2. MSB_FIRST=0, same bytes -> cmd=0x0F3CA5. Then clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd stays 0x0F3CA5.
// 3. TIMEOUT_CYCLES=16: bytes 11,22 then 16 idle cycles -> frame_err 1-cycle pulse, cmd unchanged. Then 01,02,03 -> cmd=0x010203. Also a byte on the expiry cycle -> no frame_err.
// 4. RESP_BYTES=2, resp=0xBEEF, send_resp -> trmt pulse with tx_data=BE; after tx_done, trmt with tx_data=EF; after tx_done, resp_done pulse and resp_busy=0. A send_resp with 0x1234 mid-transfer is ignored.
// 5. Set/clear collision: clr_cmd_rdy asserted on the edge of a completing byte -> cmd_rdy=1. New frame first byte while cmd_rdy=1 -> cmd_rdy=0.
// 6. rst asserted after 2 of 3 bytes and mid-response -> all outputs 0 next cycle; the next 3 bytes form a full new cmd; no spurious trmt.

Source files
------------

// File: rtl/uart_cmd_framer_if.sv
// uart_cmd_framer_if: framer bus; UART rx side (rx_rdy/rx_data/clr_rx_rdy), command side (cmd/cmd_rdy/clr_cmd_rdy/frame_err), response side (resp/send_resp/resp_busy/resp_done), UART tx side (trmt/tx_data/tx_done)
interface uart_cmd_framer_if #(
  parameter int CMD_BYTES = 3,
  parameter int RESP_BYTES = 2
);
  logic rx_rdy;
  logic [7:0] rx_data;
  logic clr_rx_rdy;
  logic [8*CMD_BYTES-1:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic frame_err;
  logic [8*RESP_BYTES-1:0] resp;
  logic send_resp;
  logic resp_busy;
  logic resp_done;
  logic trmt;
  logic [7:0] tx_data;
  logic tx_done;
  modport slave (
    input rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, resp_done, trmt, tx_data
  );
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, resp_done, trmt, tx_data
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: packs CMD_BYTES UART bytes into cmd (inter-byte timeout drops partial frames) and serialises resp into UART bytes; ports clk, rst, bus (slave side of uart_cmd_framer_if)
module uart_cmd_framer #(
  parameter int CMD_BYTES = 3,
  parameter int RESP_BYTES = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  uart_cmd_framer_if.slave bus
);
  localparam int CW = 8 * CMD_BYTES;
  localparam int CNTW = CMD_BYTES > 1 ? $clog2(CMD_BYTES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int IW = RESP_BYTES > 1 ? $clog2(RESP_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  logic [CW-1:0] r_frame, r_cmd, w_frame;
  logic [CNTW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic r_cmd_rdy, r_frame_err, w_last, w_expire, w_set, w_clr, w_tx_last;
  state_t r_state, w_next;
  logic [8*RESP_BYTES-1:0] r_resp;
  logic [IW-1:0] r_idx, w_sel;
  assign w_frame = MSB_FIRST ? (r_frame << 8) | CW'(bus.rx_data)
                             : (r_frame >> 8) | (CW'(bus.rx_data) << (CW - 8));
  assign w_last = r_cnt == CNTW'(CMD_BYTES - 1);
  assign w_expire = TIMEOUT_CYCLES != 0 && r_cnt != '0 && r_timer == TW'(TIMEOUT_CYCLES);
  assign w_set = bus.rx_rdy && w_last;
  assign w_clr = bus.clr_cmd_rdy || (bus.rx_rdy && r_cnt == '0);
  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.cmd = r_cmd;
  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.frame_err = r_frame_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_cmd <= '0;
      r_cnt <= '0;
      r_timer <= '0;
      r_cmd_rdy <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // a byte arriving on the expiry cycle continues the frame instead of erroring
      r_frame_err <= w_expire && !bus.rx_rdy;
      r_cmd_rdy <= w_set || (r_cmd_rdy && !w_clr);
      if (bus.rx_rdy) begin
        r_frame <= w_frame;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        r_timer <= '0;
        if (w_last) r_cmd <= w_frame;
      end else if (w_expire) begin
        r_frame <= '0;
        r_cnt <= '0;
        r_timer <= '0;
      end else if (r_cnt != '0 && r_timer != TW'(TIMEOUT_CYCLES)) r_timer <= r_timer + 1'b1;
    end
  end
  assign w_tx_last = r_idx == IW'(RESP_BYTES - 1);
  assign w_sel = MSB_FIRST ? IW'(RESP_BYTES - 1) - r_idx : r_idx;
  // index is left on the last byte after completion, so tx_data keeps showing it in IDLE
  assign bus.tx_data = r_resp[8*w_sel +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_resp <= '0;
      r_idx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.send_resp) begin
        r_resp <= bus.resp;
        r_idx <= '0;
      end else if (r_state == WAIT && bus.tx_done && !w_tx_last) r_idx <= r_idx + 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    bus.trmt = r_state == LOAD;
    bus.resp_busy = r_state != IDLE;
    bus.resp_done = r_state == WAIT && bus.tx_done && w_tx_last;
    w_next = r_state == IDLE ? (bus.send_resp ? LOAD : IDLE)
           : r_state == LOAD ? WAIT
           : !bus.tx_done ? WAIT
           : w_tx_last ? IDLE : LOAD;
  end
endmodule
